// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg: shared pipeline constants for the IF/ID instruction queue.
//   Stop/NoStop : polarity of a stall vector bit
//   ZeroWord    : all-zero 32-bit word
//   IfIdDepth   : default queue depth
//   IfIdCntBus  : occupancy counter width for the default depth
package if_id_buf_pkg;
    localparam logic Stop = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0;
    localparam int IfIdDepth = 4;
    localparam int IfIdCntBus = $clog2(IfIdDepth + 1);
endpackage

// File: rtl/if_id_buf_if.sv
// if_id_buf_if: fetch-side handshake and decode-side triple of the IF/ID boundary.
//   if_pc/if_inst/if_valid : instruction presented by IF
//   if_ready               : queue can accept this cycle
//   id_pc/id_inst/id_valid : registered instruction handed to ID
//   master = pipeline side, slave = if_id_buf
interface if_id_buf_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic if_valid;
    logic if_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic id_valid;
    modport master (
        output if_pc, if_inst, if_valid,
        input if_ready, id_pc, id_inst, id_valid
    );
    modport slave (
        input if_pc, if_inst, if_valid,
        output if_ready, id_pc, id_inst, id_valid
    );
endinterface

// File: rtl/if_id_buf_fifo_mem.sv
// ifid_fifo_mem: DEPTH x W queue storage, one synchronous write port, one asynchronous read port.
//   clk         : clock
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module ifid_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input logic clk,
    input logic we,
    input logic [$clog2(DEPTH)-1:0] waddr,
    input logic [W-1:0] wdata,
    input logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_buf.sv
// if_id_buf: IF/ID pipeline boundary with a DEPTH-entry instruction queue.
//   clk, rst : clock, synchronous active-high reset
//   bus      : if_id_buf_if.slave (IF handshake in, registered pc/inst/valid out to ID)
//   flush    : empty the queue, drop the presented instruction, load a bubble
//   stall    : pipeline stall vector, only stall[2] (ID hold) is used here
//   count    : queue occupancy
// Build option IFID_BYPASS_EN: an instruction arriving at an empty queue while ID
// advances goes straight to the output register (1-cycle latency instead of 2).
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH = IfIdDepth
) (
    input logic clk,
    input logic rst,
    if_id_buf_if.slave bus,
    input logic flush,
    input logic [5:0] stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W = ADDR_W + INST_W;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [W-1:0] head;
    logic enq, adv, deq, byp, wr_en;
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[1:0]};
    assign bus.if_ready = count != CW'(DEPTH);
    assign enq = bus.if_valid && bus.if_ready && !flush;
    assign adv = (stall[2] == NoStop) && !flush;
    assign deq = adv && count != '0;
`ifdef IFID_BYPASS_EN
    assign byp = enq && adv && count == '0;
`else
    assign byp = 1'b0;
`endif
    // a bypassed instruction never touches the queue
    assign wr_en = enq && !byp;
    ifid_fifo_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clk(clk),
        .we(wr_en),
        .waddr(wr_ptr),
        .wdata({bus.if_pc, bus.if_inst}),
        .raddr(rd_ptr),
        .rdata(head)
    );
    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            bus.id_pc <= '0;
            bus.id_inst <= '0;
            bus.id_valid <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(deq);
            if (adv) begin
                {bus.id_pc, bus.id_inst} <= deq ? head : byp ? {bus.if_pc, bus.if_inst} : '0;
                bus.id_valid <= deq || byp;
            end
        end
    end
endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf: self-checking bench for if_id_buf (table vectors, queue scoreboard, corner sequences).
module tb_if_id_buf;
    localparam int DEPTH = 4;
`ifdef IFID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;
    typedef struct {
        logic v;
        logic [31:0] pc;
        logic st;
        logic fl;
        logic nb_v;
        logic [31:0] nb_pc;
        int nb_cnt;
        logic b_v;
        logic [31:0] b_pc;
        int b_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [5:0] stall = '0;
    logic [2:0] count;
    if_id_buf_if #(.ADDR_W(32), .INST_W(32)) bus();
    if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .flush(flush),
        .stall(stall),
        .count(count)
    );
    always #5 clk = ~clk;

    entry_t sbq[$];
    entry_t exp_out = '0;
    logic exp_v = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] ins(logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [31:0] pc);
        bus.if_valid = v;
        bus.if_pc = pc;
        bus.if_inst = ins(pc);
    endtask

    // Scoreboard: enqueued instructions are pushed, ID advances pop the oldest.
    task automatic tick();
        logic m_enq, m_adv;
        m_enq = bus.if_valid && sbq.size() != DEPTH && !flush;
        m_adv = !stall[2] && !flush;
        if (rst || flush) begin
            sbq.delete();
            exp_out = '0;
            exp_v = 1'b0;
        end else begin
            if (m_adv) begin
                if (sbq.size() > 0) begin
                    exp_out = sbq.pop_front();
                    exp_v = 1'b1;
                end else if (BYP && m_enq) begin
                    exp_out = {bus.if_pc, bus.if_inst};
                    exp_v = 1'b1;
                    m_enq = 1'b0;
                end else begin
                    exp_out = '0;
                    exp_v = 1'b0;
                end
            end
            if (m_enq) sbq.push_back({bus.if_pc, bus.if_inst});
        end
        @(posedge clk);
        #1;
        chk("sb_id_pc", bus.id_pc, exp_out.pc);
        chk("sb_id_inst", bus.id_inst, exp_out.inst);
        chk("sb_id_valid", 32'(bus.id_valid), 32'(exp_v));
        chk("sb_count", 32'(count), 32'(sbq.size()));
        chk("sb_if_ready", 32'(bus.if_ready), 32'(sbq.size() != DEPTH));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        logic [31:0] got[$];
        int i;
        logic acc;
        logic ev;
        logic [31:0] epc;
        drive(1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(bus.if_ready), 32'd1);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        rst = 1'b0;

        // v, pc, stall2, flush | no-bypass valid/pc/count | bypass valid/pc/count
        tbl = '{
            '{1'b1, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 1, 1'b1, 32'h00, 0},
            '{1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 32'h04, 0},
            '{1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 32'h04, 1, 1'b1, 32'h08, 0},
            '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h08, 0, 1'b0, 32'h00, 0},
            '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h00, 0},
            '{1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h00, 1, 1'b0, 32'h00, 1},
            '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h20, 0, 1'b1, 32'h20, 0},
            '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h20, 0, 1'b1, 32'h20, 0},
            '{1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 32'h00, 0, 1'b0, 32'h00, 0},
            '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 0, 1'b0, 32'h00, 0}
        };
        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].pc);
            stall[2] = tbl[k].st;
            flush = tbl[k].fl;
            tick();
            ev = BYP ? tbl[k].b_v : tbl[k].nb_v;
            epc = BYP ? tbl[k].b_pc : tbl[k].nb_pc;
            chk("tbl_valid", 32'(bus.id_valid), 32'(ev));
            chk("tbl_pc", bus.id_pc, epc);
            chk("tbl_inst", bus.id_inst, ev ? ins(epc) : 32'h0);
            chk("tbl_count", 32'(count), 32'(BYP ? tbl[k].b_cnt : tbl[k].nb_cnt));
        end
        flush = 1'b0;

        // stalled ID fills the queue; the fifth instruction waits at IF
        stall[2] = 1'b1;
        i = 0;
        repeat (8) begin
            drive(i < 5, 32'h40 + 32'(4 * i));
            acc = bus.if_ready;
            tick();
            if (acc && i < 5) i++;
            chk("stall_id_valid", 32'(bus.id_valid), 32'd0);
            chk("stall_id_pc", bus.id_pc, 32'h0);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(bus.if_ready), 32'd0);
        chk("full_accepted", 32'(i), 32'd4);
        stall[2] = 1'b0;
        got.delete();
        for (int g = 0; g < 15 && got.size() < 5; g++) begin
            drive(i < 5, 32'h40 + 32'(4 * i));
            acc = bus.if_ready;
            tick();
            if (acc && i < 5) i++;
            if (bus.id_valid) got.push_back(bus.id_pc);
        end
        chk("drain_n", 32'(got.size()), 32'd5);
        foreach (got[j]) chk("drain_order", got[j], 32'h40 + 32'(4 * j));
        drive(1'b0, 32'h0);

        // flush on a full queue with an instruction presented
        stall[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h80 + 32'(4 * k));
            tick();
        end
        chk("pre_flush_count", 32'(count), 32'd4);
        flush = 1'b1;
        drive(1'b1, 32'hDEAD0);
        tick();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(bus.id_valid), 32'd0);
        chk("flush_inst", bus.id_inst, 32'h0);
        chk("flush_ready", 32'(bus.if_ready), 32'd1);
        flush = 1'b0;
        stall[2] = 1'b0;
        drive(1'b0, 32'h0);
        repeat (4) begin
            tick();
            chk("no_ghost", 32'(bus.id_valid), 32'd0);
        end

        // steady state at count 2 with pointer wrap
        stall[2] = 1'b1;
        drive(1'b1, 32'h200);
        tick();
        drive(1'b1, 32'h204);
        tick();
        stall[2] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 32'h208 + 32'(4 * j));
            tick();
            chk("steady_count", 32'(count), 32'd2);
            chk("steady_pc", bus.id_pc, 32'h200 + 32'(4 * j));
            chk("steady_valid", 32'(bus.id_valid), 32'd1);
        end

        // reset mid-stream with three queued
        stall[2] = 1'b1;
        drive(1'b1, 32'h300);
        tick();
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        drive(1'b1, 32'h3FC);
        tick();
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_mid_pc", bus.id_pc, 32'h0);
        chk("rst_mid_inst", bus.id_inst, 32'h0);
        rst = 1'b0;
        stall[2] = 1'b0;
        drive(1'b1, 32'h100);
        tick();
        got.delete();
        if (bus.id_valid) got.push_back(bus.id_pc);
        drive(1'b0, 32'h0);
        repeat (4) begin
            tick();
            if (bus.id_valid) got.push_back(bus.id_pc);
        end
        chk("post_rst_n", 32'(got.size()), 32'd1);
        chk("post_rst_first", got.size() != 0 ? got[0] : 32'hFFFF_FFFF, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised IF/ID pipeline boundary; next generation of the single-entry IF/ID latch.
- A DEPTH-entry instruction queue decouples fetch from decode, so IF keeps fetching while ID is stalled.
- Outputs a registered (pc, inst, valid) triple to ID.
- Supports flush on branch/exception; a flush empties the queue and inserts a bubble.

Parameters:
- ADDR_W, 32, width of pc
- INST_W, 32, width of instruction word
- DEPTH, 4, queue entries; power of two, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- if_pc  in  ADDR_W  pc of fetched instruction
- if_inst  in  INST_W  fetched instruction
- if_valid  in  1  IF presents an instruction this cycle
- if_ready  out  1  queue can accept; equals (count != DEPTH)
- flush  in  1  discard all queued and presented instructions
- stall  in  6  pipeline stall vector; stall[2]==Stop holds ID
- id_pc  out  ADDR_W  pc to ID
- id_inst  out  INST_W  instruction to ID
- id_valid  out  1  id_pc/id_inst hold a real instruction
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- All state updates occur on posedge clk.
- Reset, highest priority:
  - rd_ptr = wr_ptr = count = 0.
  - id_pc = 0, id_inst = 0, id_valid = 0.
  - if_ready = 1 from the cycle after reset.
- Flush, second priority:
  - Queue emptied (pointers and count to 0).
  - id_pc, id_inst and id_valid all set to 0.
  - An if_valid in the same cycle is dropped.
  - stall is ignored in that cycle.
- Enqueue:
  - Condition: enq = if_valid && if_ready && !flush.
  - Writes mem[wr_ptr] and increments wr_ptr, wrapping modulo DEPTH.
- ID advance:
  - Condition: adv = (stall[2]==NoStop) && !flush.
  - adv with count>0: output register loads mem[rd_ptr], id_valid = 1, rd_ptr increments (wraps).
  - adv with count==0: bubble loaded (id_pc = 0, id_inst = 0, id_valid = 0).
  - stall[2]==Stop: output register and rd_ptr hold.
- Count update:
  - count_next = count + enq - deq, where deq = adv && count>0.
  - Enqueue and dequeue in the same cycle leaves count unchanged.
- Full: if_ready = 0, if_valid ignored, nothing lost; IF must hold its inputs.
- Empty and stalled: output holds its current contents, which may be valid.
- Latency: 2 cycles from enq to the instruction appearing at id_* (write, then read) when ID is not stalled.
- Order: strictly FIFO; pc/inst pairs never split or reordered.
- stall[5:3] and stall[1:0] are unused here; stall[1] is consumed by pc_reg.

Optional Feature:
- Macro: IFID_BYPASS_EN.
- Defined: when count==0, adv and enq occur together, if_pc/if_inst load directly into the output register with id_valid = 1. The queue is not written and the count is unchanged. Latency becomes 1 cycle.
- Undefined: no bypass, 2-cycle latency as above.
- Flush still overrides the bypass in both builds.

Decomposition:
- Shared defines file (existing, alongside RstEnable/Stop/NoStop/ZeroWord) gains:
  - IfIdDepth default value.
  - IfIdCntBus width macro.
- Polarity constants (Stop/NoStop, ZeroWord) are reused from the defines file. Reset is fixed active-high and is not taken from RstEnable.
- Sub-module ifid_fifo_mem: DEPTH x (ADDR_W+INST_W) storage with one synchronous write port and one asynchronous read port. Pointers, count and output register stay in if_id_buf.

Test Plan:
- Reset then three fetches (pc 0x0,0x4,0x8), no stall -> id_pc sequence 0x0,0x4,0x8 on cycles 2,3,4 after first enq (1,2,3 with IFID_BYPASS_EN); id_valid high on exactly those cycles.
- Hold stall[2]=Stop while feeding 5 instrs, DEPTH=4 -> count reaches 4, if_ready=0 on the cycle after the 4th enq, 5th held by IF; id_* unchanged throughout; release -> 5 instrs exit in order.
- Full queue, flush for one cycle with if_valid=1 -> next cycle count=0, id_valid=0, id_inst=0, if_ready=1; dropped instr never appears.
- Steady state count=2, enq and adv every cycle for 10 cycles -> count stays 2, no loss or duplicate, pointers wrap past DEPTH correctly.
- Empty queue, adv with no enq -> bubble: id_pc=0, id_inst=0, id_valid=0; with stall[2]=Stop instead -> previous valid instr held.
- rst asserted mid-stream with count=3 -> next cycle all outputs 0, count=0; following fetch of pc 0x100 emerges as first instruction.
